// File: rtl/alu_step_sequencer.sv
// -----------------------------------------------------------------------------
// alu_step_sequencer
//
// Registered Moore FSM that drives the datapath's control strobes for one
// register-register or register-immediate ALU instruction, steps T3..T6.
// Each step is held for STEP_CYCLES clock cycles. MUL/DIV take an extra step
// (T6) to write the 64-bit result back to HI/LO.
//
// Ports
//   clk        in   system clock, rising edge
//   clr        in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE
//   opcode     in   ALU operation (latched on accept)
//   ra/rb/rc   in   destination / first source / second source register index
//   imm_mode   in   1 = second operand from C-sign-extended (Cout)
//   busy       out  high whenever state != IDLE
//   done       out  one-cycle completion pulse
//   Rin/Rout   out  one-hot register load / drive enables
//   Yin, Zin, ZLOout, ZHIout, HIin, LOin, Cout   out  datapath strobes
//   ALU_opcode out  opcode presented to the ALU (T4 through DONE)
//   step       out  current state encoding, for debug
// -----------------------------------------------------------------------------
module alu_step_sequencer #(
  parameter int                NUM_REGS    = 16,
  parameter int                REG_SEL_W   = 4,
  parameter int                OPC_W       = 5,
  parameter int                STEP_CYCLES = 1,
  parameter logic [OPC_W-1:0]  OPC_MUL     = 5'b01110,
  parameter logic [OPC_W-1:0]  OPC_DIV     = 5'b01111
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [OPC_W-1:0]      opcode,
  input  logic [REG_SEL_W-1:0]  ra,
  input  logic [REG_SEL_W-1:0]  rb,
  input  logic [REG_SEL_W-1:0]  rc,
  input  logic                  imm_mode,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  ZLOout,
  output logic                  ZHIout,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  Cout,
  output logic [OPC_W-1:0]      ALU_opcode,
  output logic [2:0]            step
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(STEP_CYCLES - 1);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [OPC_W-1:0]      r_opc;
  logic [REG_SEL_W-1:0]  r_ra, r_rb, r_rc;
  logic                  r_imm;

  state_t                w_state_nxt;
  logic [3:0]            w_cnt_nxt;
  logic [OPC_W-1:0]      w_opc_nxt;
  logic [REG_SEL_W-1:0]  w_ra_nxt, w_rb_nxt, w_rc_nxt;
  logic                  w_imm_nxt;
  logic                  w_step_end;
  logic                  w_wide;

  logic [NUM_REGS-1:0]   w_rin_nxt, w_rout_nxt;
  logic                  w_yin_nxt, w_zin_nxt, w_zlo_nxt, w_zhi_nxt;
  logic                  w_hiin_nxt, w_loin_nxt, w_cout_nxt;
  logic [OPC_W-1:0]      w_alu_nxt;

  // Out-of-range indices select nothing rather than aliasing onto a register.
  function automatic logic [NUM_REGS-1:0] one_hot(input logic [REG_SEL_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (int'(idx) < NUM_REGS) v[idx] = 1'b1;
    return v;
  endfunction

  assign w_step_end = (r_cnt == LAST_CNT);
  assign w_wide     = (r_opc == OPC_MUL) || (r_opc == OPC_DIV);

  // Next-state and field-latch logic.
  // NOTE: every signal gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_opc_nxt   = r_opc;
    w_ra_nxt    = r_ra;
    w_rb_nxt    = r_rb;
    w_rc_nxt    = r_rc;
    w_imm_nxt   = r_imm;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_T3;
          w_cnt_nxt   = '0;
          w_opc_nxt   = opcode;
          w_ra_nxt    = ra;
          w_rb_nxt    = rb;
          w_rc_nxt    = rc;
          w_imm_nxt   = imm_mode;
        end
      end
      S_T3, S_T4, S_T5, S_T6: begin
        if (w_step_end) begin
          w_cnt_nxt = '0;
          case (r_state)
            S_T3:    w_state_nxt = S_T4;
            S_T4:    w_state_nxt = S_T5;
            S_T5:    w_state_nxt = w_wide ? S_T6 : S_DONE;
            default: w_state_nxt = S_DONE;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the *next* state and fields, so the registered outputs
  // line up with the state they belong to (Moore, no input-to-output path).
  always_comb begin
    w_rin_nxt  = '0;
    w_rout_nxt = '0;
    w_yin_nxt  = 1'b0;
    w_zin_nxt  = 1'b0;
    w_zlo_nxt  = 1'b0;
    w_zhi_nxt  = 1'b0;
    w_hiin_nxt = 1'b0;
    w_loin_nxt = 1'b0;
    w_cout_nxt = 1'b0;
    w_alu_nxt  = '0;

    unique case (w_state_nxt)
      S_T3: begin
        w_rout_nxt = one_hot(w_rb_nxt);
        w_yin_nxt  = 1'b1;
      end
      S_T4: begin
        w_zin_nxt = 1'b1;
        w_alu_nxt = w_opc_nxt;
        if (w_imm_nxt) w_cout_nxt = 1'b1;
        else           w_rout_nxt = one_hot(w_rc_nxt);
      end
      S_T5: begin
        w_zlo_nxt = 1'b1;
        w_alu_nxt = w_opc_nxt;
        if ((w_opc_nxt == OPC_MUL) || (w_opc_nxt == OPC_DIV)) w_loin_nxt = 1'b1;
        else                                                  w_rin_nxt  = one_hot(w_ra_nxt);
      end
      S_T6: begin
        w_zhi_nxt  = 1'b1;
        w_hiin_nxt = 1'b1;
        w_alu_nxt  = w_opc_nxt;
      end
      S_DONE:  w_alu_nxt = w_opc_nxt;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_opc      <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_imm      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Rin        <= '0;
      Rout       <= '0;
      Yin        <= 1'b0;
      Zin        <= 1'b0;
      ZLOout     <= 1'b0;
      ZHIout     <= 1'b0;
      HIin       <= 1'b0;
      LOin       <= 1'b0;
      Cout       <= 1'b0;
      ALU_opcode <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_opc      <= w_opc_nxt;
      r_ra       <= w_ra_nxt;
      r_rb       <= w_rb_nxt;
      r_rc       <= w_rc_nxt;
      r_imm      <= w_imm_nxt;
      busy       <= (w_state_nxt != S_IDLE);
      done       <= (w_state_nxt == S_DONE);
      Rin        <= w_rin_nxt;
      Rout       <= w_rout_nxt;
      Yin        <= w_yin_nxt;
      Zin        <= w_zin_nxt;
      ZLOout     <= w_zlo_nxt;
      ZHIout     <= w_zhi_nxt;
      HIin       <= w_hiin_nxt;
      LOin       <= w_loin_nxt;
      Cout       <= w_cout_nxt;
      ALU_opcode <= w_alu_nxt;
    end
  end

  assign step = r_state;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_step_sequencer
//
// Directed bench for alu_step_sequencer. Three instances share clock, reset
// and instruction fields, each with its own start:
//   u_dut1  defaults (NUM_REGS=16, STEP_CYCLES=1)
//   u_dut2  STEP_CYCLES=2 (wide MUL/DIV, mid-op reset)
//   u_dut3  NUM_REGS=12 (out-of-range destination)
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_step_sequencer;

  localparam logic [6:0] S_YIN = 7'b1000000;
  localparam logic [6:0] S_ZIN = 7'b0100000;
  localparam logic [6:0] S_ZLO = 7'b0010000;
  localparam logic [6:0] S_ZHI = 7'b0001000;
  localparam logic [6:0] S_HI  = 7'b0000100;
  localparam logic [6:0] S_LO  = 7'b0000010;
  localparam logic [6:0] S_C   = 7'b0000001;

  typedef struct packed {
    logic [2:0]  step;
    logic        busy;
    logic        done;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [6:0]  strb;
    logic [4:0]  alu;
  } snap_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       start1, start2, start3;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       imm_mode;

  logic        busy1, done1, yin1, zin1, zlo1, zhi1, hi1, lo1, c1;
  logic [15:0] rin1, rout1;
  logic [4:0]  alu1;
  logic [2:0]  step1;

  logic        busy2, done2, yin2, zin2, zlo2, zhi2, hi2, lo2, c2;
  logic [15:0] rin2, rout2;
  logic [4:0]  alu2;
  logic [2:0]  step2;

  logic        busy3, done3, yin3, zin3, zlo3, zhi3, hi3, lo3, c3;
  logic [11:0] rin3, rout3;
  logic [4:0]  alu3;
  logic [2:0]  step3;

  snap_t s1, s2, s3;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_step_sequencer u_dut1 (
    .clk(clk), .clr(clr), .start(start1), .opcode(opcode), .ra(ra), .rb(rb),
    .rc(rc), .imm_mode(imm_mode), .busy(busy1), .done(done1), .Rin(rin1),
    .Rout(rout1), .Yin(yin1), .Zin(zin1), .ZLOout(zlo1), .ZHIout(zhi1),
    .HIin(hi1), .LOin(lo1), .Cout(c1), .ALU_opcode(alu1), .step(step1));

  alu_step_sequencer #(.STEP_CYCLES(2)) u_dut2 (
    .clk(clk), .clr(clr), .start(start2), .opcode(opcode), .ra(ra), .rb(rb),
    .rc(rc), .imm_mode(imm_mode), .busy(busy2), .done(done2), .Rin(rin2),
    .Rout(rout2), .Yin(yin2), .Zin(zin2), .ZLOout(zlo2), .ZHIout(zhi2),
    .HIin(hi2), .LOin(lo2), .Cout(c2), .ALU_opcode(alu2), .step(step2));

  alu_step_sequencer #(.NUM_REGS(12)) u_dut3 (
    .clk(clk), .clr(clr), .start(start3), .opcode(opcode), .ra(ra), .rb(rb),
    .rc(rc), .imm_mode(imm_mode), .busy(busy3), .done(done3), .Rin(rin3),
    .Rout(rout3), .Yin(yin3), .Zin(zin3), .ZLOout(zlo3), .ZHIout(zhi3),
    .HIin(hi3), .LOin(lo3), .Cout(c3), .ALU_opcode(alu3), .step(step3));

  assign s1 = {step1, busy1, done1, rin1, rout1,
               {yin1, zin1, zlo1, zhi1, hi1, lo1, c1}, alu1};
  assign s2 = {step2, busy2, done2, rin2, rout2,
               {yin2, zin2, zlo2, zhi2, hi2, lo2, c2}, alu2};
  assign s3 = {step3, busy3, done3, {4'b0, rin3}, {4'b0, rout3},
               {yin3, zin3, zlo3, zhi3, hi3, lo3, c3}, alu3};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of instance d against one expected cycle.
  task automatic cyc(input int d, input string tag, input logic [2:0] st,
                     input logic bz, input logic dn, input logic [15:0] rin,
                     input logic [15:0] rout, input logic [6:0] strb,
                     input logic [4:0] alu);
    snap_t o;
    case (d)
      1:       o = s1;
      2:       o = s2;
      default: o = s3;
    endcase
    check({tag, ".step"}, 16'(o.step), 16'(st));
    check({tag, ".busy"}, 16'(o.busy), 16'(bz));
    check({tag, ".done"}, 16'(o.done), 16'(dn));
    check({tag, ".Rin"},  o.rin, rin);
    check({tag, ".Rout"}, o.rout, rout);
    check({tag, ".strb"}, 16'(o.strb), 16'(strb));
    check({tag, ".alu"},  16'(o.alu), 16'(alu));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0;
    start1 = 1'b1; start2 = 1'b1; start3 = 1'b1;
    opcode = 5'b00011; ra = 4'd0; rb = 4'd4; rc = 4'd3; imm_mode = 1'b0;

    // Reset held with start asserted: everything stays quiet.
    nxt(); nxt();
    cyc(1, "rst1", 3'd0, 0, 0, 16'h0, 16'h0, 7'h0, 5'd0);
    cyc(2, "rst2", 3'd0, 0, 0, 16'h0, 16'h0, 7'h0, 5'd0);
    cyc(3, "rst3", 3'd0, 0, 0, 16'h0, 16'h0, 7'h0, 5'd0);

    // Release; SUB on dut1 is accepted on the very next edge.
    clr = 1'b1; start2 = 1'b0; start3 = 1'b0;
    nxt(); start1 = 1'b0;
    cyc(1, "sub.t3",   3'd1, 1, 0, 16'h0,    16'h0010, S_YIN, 5'd0);
    nxt(); cyc(1, "sub.t4",   3'd2, 1, 0, 16'h0,    16'h0008, S_ZIN, 5'd3);
    nxt(); cyc(1, "sub.t5",   3'd3, 1, 0, 16'h0001, 16'h0,    S_ZLO, 5'd3);
    nxt(); cyc(1, "sub.done", 3'd5, 1, 1, 16'h0,    16'h0,    7'h0,  5'd3);
    // Back-to-back: start sampled in the idle cycle after done.
    start1 = 1'b1; imm_mode = 1'b1; rc = 4'd7;
    nxt(); cyc(1, "sub.idle", 3'd0, 0, 0, 16'h0,    16'h0,    7'h0,  5'd0);

    // Immediate mode, with an overlapping start during T4.
    nxt(); start1 = 1'b0;
    cyc(1, "imm.t3",   3'd1, 1, 0, 16'h0,    16'h0010, S_YIN, 5'd0);
    nxt(); cyc(1, "imm.t4",   3'd2, 1, 0, 16'h0,    16'h0,    S_ZIN | S_C, 5'd3);
    start1 = 1'b1; opcode = 5'b00001; ra = 4'd2; rb = 4'd1; rc = 4'd6; imm_mode = 1'b0;
    nxt(); cyc(1, "imm.t5",   3'd3, 1, 0, 16'h0001, 16'h0,    S_ZLO, 5'd3);
    nxt(); cyc(1, "imm.done", 3'd5, 1, 1, 16'h0,    16'h0,    7'h0,  5'd3);
    // start still high: ignored in DONE, accepted in the following IDLE.
    nxt(); cyc(1, "b2b.idle", 3'd0, 0, 0, 16'h0,    16'h0,    7'h0,  5'd0);
    nxt(); start1 = 1'b0;
    cyc(1, "b2b.t3",   3'd1, 1, 0, 16'h0,    16'h0002, S_YIN, 5'd0);
    nxt(); cyc(1, "b2b.t4",   3'd2, 1, 0, 16'h0,    16'h0040, S_ZIN, 5'd1);
    nxt(); cyc(1, "b2b.t5",   3'd3, 1, 0, 16'h0004, 16'h0,    S_ZLO, 5'd1);
    nxt(); cyc(1, "b2b.done", 3'd5, 1, 1, 16'h0,    16'h0,    7'h0,  5'd1);
    nxt(); cyc(1, "b2b.idle", 3'd0, 0, 0, 16'h0,    16'h0,    7'h0,  5'd0);

    // MUL on dut2 with two cycles per step; done on cycle 9.
    start2 = 1'b1; opcode = 5'b01110; ra = 4'd0; rb = 4'd2; rc = 4'd5;
    for (int i = 0; i < 2; i++) begin
      nxt(); start2 = 1'b0;
      cyc(2, "mul.t3", 3'd1, 1, 0, 16'h0, 16'h0004, S_YIN, 5'd0);
    end
    for (int i = 0; i < 2; i++) begin
      nxt(); cyc(2, "mul.t4", 3'd2, 1, 0, 16'h0, 16'h0020, S_ZIN, 5'h0E);
    end
    for (int i = 0; i < 2; i++) begin
      nxt(); cyc(2, "mul.t5", 3'd3, 1, 0, 16'h0, 16'h0, S_ZLO | S_LO, 5'h0E);
    end
    for (int i = 0; i < 2; i++) begin
      nxt(); cyc(2, "mul.t6", 3'd4, 1, 0, 16'h0, 16'h0, S_ZHI | S_HI, 5'h0E);
    end
    nxt(); cyc(2, "mul.done", 3'd5, 1, 1, 16'h0, 16'h0, 7'h0, 5'h0E);
    nxt(); cyc(2, "mul.idle", 3'd0, 0, 0, 16'h0, 16'h0, 7'h0, 5'd0);

    // NUM_REGS=12 instance with ra=13: no Rin bit, done still pulses.
    start3 = 1'b1; opcode = 5'b00011; ra = 4'd13; rb = 4'd1; rc = 4'd2;
    nxt(); start3 = 1'b0;
    cyc(3, "oor.t3",   3'd1, 1, 0, 16'h0, 16'h0002, S_YIN, 5'd0);
    nxt(); cyc(3, "oor.t4",   3'd2, 1, 0, 16'h0, 16'h0004, S_ZIN, 5'd3);
    nxt(); cyc(3, "oor.t5",   3'd3, 1, 0, 16'h0, 16'h0,    S_ZLO, 5'd3);
    nxt(); cyc(3, "oor.done", 3'd5, 1, 1, 16'h0, 16'h0,    7'h0,  5'd3);

    // DIV on dut2, reset asynchronously in the middle of T5.
    start2 = 1'b1; opcode = 5'b01111; ra = 4'd1; rb = 4'd3; rc = 4'd4;
    nxt(); start2 = 1'b0;
    nxt(); nxt(); nxt(); nxt();
    cyc(2, "div.t5", 3'd3, 1, 0, 16'h0, 16'h0, S_ZLO | S_LO, 5'h0F);
    #2 clr = 1'b0;
    #1 cyc(2, "div.rst", 3'd0, 0, 0, 16'h0, 16'h0, 7'h0, 5'd0);
    nxt(); clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nxt();
      check("div.nodone", 16'(done2), 16'h0);
      check("div.nobusy", 16'(busy2), 16'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_step_sequencer.md
# alu_step_sequencer

Parametrised control-step sequencer that drives the datapath's register-transfer control signals for one register-register or register-immediate ALU instruction (steps T3..T6). It replaces hand-timed control sequencing with a registered Moore FSM. It accepts decoded instruction fields over a start/busy/done handshake and emits one-hot register enables, Y/Z/HI/LO strobes and the ALU opcode. It adds a configurable step length, an immediate-operand mode, and 64-bit result write-back to HI/LO for MUL/DIV.

## Interface
Parameters:
- NUM_REGS, 16, number of general registers; width of the Rin/Rout vectors.
- REG_SEL_W, 4, width of a register index; must satisfy 2**REG_SEL_W >= NUM_REGS.
- OPC_W, 5, ALU opcode width.
- STEP_CYCLES, 1, clock cycles each control step is held; valid range 1..15.
- OPC_MUL, 5'b01110, opcode that produces a 64-bit result.
- OPC_DIV, 5'b01111, opcode that produces a 64-bit result.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- opcode  in  OPC_W  ALU operation.
- ra  in  REG_SEL_W  destination register.
- rb  in  REG_SEL_W  first source register.
- rc  in  REG_SEL_W  second source register; ignored when imm_mode=1.
- imm_mode  in  1  1 = second operand taken from C-sign-extended (Cout).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- Rin  out  NUM_REGS  one-hot register load enables.
- Rout  out  NUM_REGS  one-hot register drive enables.
- Yin, Zin, ZLOout, ZHIout, HIin, LOin, Cout  out  1 each  datapath strobes.
- ALU_opcode  out  OPC_W  opcode presented to the ALU.
- step  out  3  current state encoding, for debug.

## Operation
- States and encodings: IDLE=0, T3=1, T4=2, T5=3, T6=4, DONE=5.
- On accept (start=1 in IDLE), latch opcode, ra, rb, rc and imm_mode; the FSM goes to T3. Inputs are not used again until the next accept.
- wide = (latched opcode == OPC_MUL) or (latched opcode == OPC_DIV).
- T3: Rout[rb]=1, Yin=1.
- T4: Zin=1, ALU_opcode=opcode.
  - imm_mode=0: Rout[rc]=1.
  - imm_mode=1: Cout=1 and no Rout bit is set.
- T5:
  - wide=0: ZLOout=1, Rin[ra]=1, then go to DONE.
  - wide=1: ZLOout=1, LOin=1, then go to T6.
- T6 (wide only): ZHIout=1, HIin=1, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- ALU_opcode holds the latched value from T4 through DONE. It is 0 in IDLE and T3.
- Every strobe not listed for a state is 0.
- At most one Rout bit and one Rin bit are ever set.
- A register index >= NUM_REGS asserts no Rin/Rout bit; the sequence still runs to DONE.
- ra, rb and rc may be equal; there is no special casing.
- start while busy is ignored and not queued.
- All outputs are registered (Moore). There is no combinational path from inputs to outputs.

## Timing
- Reset (clr=0), asynchronous and effective immediately, including mid-sequence:
  - state = IDLE, step counter = 0.
  - All outputs = 0, including Rin, Rout and ALU_opcode.
  - Latched fields = 0.
- After clr deasserts, the first start is honoured on the next rising edge.
- Each of T3, T4, T5 and T6 lasts exactly STEP_CYCLES cycles.
  - The step counter resets to 0 on every state entry.
  - The state advances when counter == STEP_CYCLES-1.
- Latency from the accept edge to the done pulse:
  - Non-wide: 3*STEP_CYCLES + 1 cycles.
  - Wide: 4*STEP_CYCLES + 1 cycles.
- busy rises on the accept edge and falls on the edge leaving DONE.
- A start sampled the cycle after done (FSM back in IDLE) is accepted, giving back-to-back operation with one idle cycle.
- Control signals change only on rising edges, so they are stable for the full step for the datapath's edge-triggered registers.

## Test plan
- Reset: hold clr=0 with start=1 -> all outputs 0, busy=0; after release, the next-edge start is accepted.
- SUB, STEP_CYCLES=1: opcode=5'b00011, ra=0, rb=4, rc=3, imm_mode=0 -> sequence:
  - T3: Rout=16'h0010, Yin.
  - T4: Rout=16'h0008, Zin, ALU_opcode=3.
  - T5: ZLOout, Rin=16'h0001.
  - done on cycle 4, busy high for 4 cycles.
- MUL, STEP_CYCLES=2: opcode=OPC_MUL, rb=2, rc=5 -> T5 asserts ZLOout+LOin, T6 asserts ZHIout+HIin, no Rin bit set, each step 2 cycles, done at cycle 9.
- Immediate mode: imm_mode=1, rc=7 -> T4 has Cout=1, Rout=0; the rest as in the SUB case.
- Busy/overlap: pulse start again during T4 with new fields -> ignored; outputs use the first latched fields; a start on the cycle after done is accepted.
- Reset mid-op: drive clr=0 during T5 of a wide op -> Rin, LOin and ZLOout drop to 0 asynchronously, no done pulse; NUM_REGS=12 with ra=13 -> no Rin bit set, done still pulses.
